// File: rtl/fp_pipe_pkg.sv
// ============================================================================
// Module : fp_pipe_pkg
// Brief  : Shared types and constants for the FP/INT core EX/MEM pipeline.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_pipe_pkg;

    localparam int XLEN_C = 32;
    localparam int REGW_C = 5;

    localparam logic [1:0] WB_SEL_LOAD = 2'd0;
    localparam logic [1:0] WB_SEL_ALU  = 2'd1;
    localparam logic [1:0] WB_SEL_FP   = 2'd2;

    typedef struct packed {
        logic [XLEN_C-1:0] alu;
        logic [XLEN_C-1:0] fp;
        logic [XLEN_C-1:0] addr;
        logic [XLEN_C-1:0] sdata;
        logic [REGW_C-1:0] rd;
        logic              mwr;
        logic              mem_en;
        logic [2:0]        width;
        logic [1:0]        wb_sel;
        logic              fp_en;
        logic              int_en;
    } ex_mem_bundle_t;

    localparam int BUNDLE_W_C = $bits(ex_mem_bundle_t);

endpackage

`default_nettype wire

// File: rtl/pipe_skid_buf.sv
// ============================================================================
// Module : pipe_skid_buf
// Brief  : Generic 2-entry valid/ready FIFO buffer with registered in_ready.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_skid_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] hold_q;
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         ready_q;
    logic         push;
    logic         pop;
    logic         head_valid;

    assign head_valid = (count_q != 2'd0);
    assign push       = in_valid & ready_q & ~flush;
    assign pop        = head_valid & out_ready & ~flush;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            hold_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d < 2'(DEPTH));
            // Track the visible head so the data outputs can hold it once empty.
            if (head_valid) begin
                hold_q <= mem_q[rd_ptr_q];
            end
            if (flush) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= in_data;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = head_valid;
    assign out_data  = head_valid ? mem_q[rd_ptr_q] : hold_q;

endmodule

`default_nettype wire

// File: rtl/ex_mem_pipeline.sv
// ============================================================================
// Module : ex_mem_pipeline
// Brief  : EX/MEM pipeline register; skid-buffered bundle plus qualified controls.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_mem_pipeline
    import fp_pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_C,
    parameter int REGW  = REGW_C,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_fp_result,
    input  logic [XLEN-1:0] ex_mem_address,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [REGW-1:0] ex_rd_addr,
    input  logic            ex_mwr,
    input  logic            ex_mem_en,
    input  logic [2:0]      ex_width,
    input  logic [1:0]      ex_wb_sel,
    input  logic            ex_wb_fp_en,
    input  logic            ex_wb_int_en,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] mem_fp_result,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_store_data,
    output logic [REGW-1:0] mem_rd_addr,
    output logic [2:0]      mem_width,
    output logic [1:0]      mem_wb_sel,
    output logic            mem_mwr,
    output logic            mem_read,
    output logic            mem_wb_fp_en,
    output logic            mem_wb_int_en,
    output logic            fwd_valid,
    output logic [REGW-1:0] fwd_rd_addr
);

    ex_mem_bundle_t in_b;
    ex_mem_bundle_t head;
    logic           head_valid;

    always_comb begin
        in_b        = '0;
        in_b.alu    = ex_alu_result;
        in_b.fp     = ex_fp_result;
        in_b.addr   = ex_mem_address;
        in_b.sdata  = ex_store_data;
        in_b.rd     = ex_rd_addr;
        in_b.mwr    = ex_mwr;
        in_b.mem_en = ex_mem_en;
        in_b.width  = ex_width;
        in_b.wb_sel = ex_wb_sel;
        in_b.fp_en  = ex_wb_fp_en;
        in_b.int_en = ex_wb_int_en;
    end

    pipe_skid_buf #(
        .W     (BUNDLE_W_C),
        .DEPTH (DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (ex_valid),
        .in_ready  (ex_ready),
        .in_data   (in_b),
        .out_valid (head_valid),
        .out_ready (mem_ready),
        .out_data  (head)
    );

    assign mem_valid      = head_valid;
    assign mem_alu_result = head.alu;
    assign mem_fp_result  = head.fp;
    assign mem_address    = head.addr;
    assign mem_store_data = head.sdata;
    assign mem_rd_addr    = head.rd;
    assign mem_width      = head.width;
    assign mem_wb_sel     = head.wb_sel;

    // Controls are gated by valid so a bubble can never write memory or a regfile.
    assign mem_mwr        =  head.mwr & head.mem_en & head_valid;
    assign mem_read       = ~head.mwr & head.mem_en & head_valid;
    assign mem_wb_fp_en   = head.fp_en  & head_valid;
    assign mem_wb_int_en  = head.int_en & head_valid;

    // x0 is hardwired zero, so integer writes to it never need forwarding.
    assign fwd_valid   = head_valid &
                         (head.fp_en | (head.int_en & (head.rd != '0)));
    assign fwd_rd_addr = head.rd;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_pipeline.sv
// ============================================================================
// Module : tb_ex_mem_pipeline
// Brief  : Self-checking bench for ex_mem_pipeline against a queue reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_pipeline;
    import fp_pipe_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           ex_valid;
    logic           mem_ready;
    ex_mem_bundle_t drv;

    logic              ex_ready, mem_valid;
    logic [XLEN_C-1:0] mem_alu_result, mem_fp_result, mem_address, mem_store_data;
    logic [REGW_C-1:0] mem_rd_addr, fwd_rd_addr;
    logic [2:0]        mem_width;
    logic [1:0]        mem_wb_sel;
    logic              mem_mwr, mem_read, mem_wb_fp_en, mem_wb_int_en, fwd_valid;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: ordered queue of accepted bundles
    ex_mem_bundle_t mq[$];
    ex_mem_bundle_t m_last  = '0;
    logic           m_ready = 1'b0;

    always #5 clk = ~clk;

    ex_mem_pipeline dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_alu_result  (drv.alu),
        .ex_fp_result   (drv.fp),
        .ex_mem_address (drv.addr),
        .ex_store_data  (drv.sdata),
        .ex_rd_addr     (drv.rd),
        .ex_mwr         (drv.mwr),
        .ex_mem_en      (drv.mem_en),
        .ex_width       (drv.width),
        .ex_wb_sel      (drv.wb_sel),
        .ex_wb_fp_en    (drv.fp_en),
        .ex_wb_int_en   (drv.int_en),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_alu_result (mem_alu_result),
        .mem_fp_result  (mem_fp_result),
        .mem_address    (mem_address),
        .mem_store_data (mem_store_data),
        .mem_rd_addr    (mem_rd_addr),
        .mem_width      (mem_width),
        .mem_wb_sel     (mem_wb_sel),
        .mem_mwr        (mem_mwr),
        .mem_read       (mem_read),
        .mem_wb_fp_en   (mem_wb_fp_en),
        .mem_wb_int_en  (mem_wb_int_en),
        .fwd_valid      (fwd_valid),
        .fwd_rd_addr    (fwd_rd_addr)
    );

    function automatic ex_mem_bundle_t rand_b();
        ex_mem_bundle_t b;
        b.alu    = $urandom;
        b.fp     = $urandom;
        b.addr   = $urandom;
        b.sdata  = $urandom;
        b.rd     = 5'($urandom);
        b.mwr    = 1'($urandom);
        b.mem_en = 1'($urandom);
        b.width  = 3'($urandom);
        b.wb_sel = 2'($urandom_range(0, 2));
        b.fp_en  = 1'($urandom);
        b.int_en = 1'($urandom);
        return b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_update();
        logic do_push, do_pop;
        if (!rst) begin
            mq.delete();
            m_last  = '0;
            m_ready = 1'b0;
        end else begin
            if (mq.size() != 0) m_last = mq[0];
            if (flush) begin
                mq.delete();
                m_ready = 1'b1;
            end else begin
                do_push = ex_valid && m_ready;
                do_pop  = (mq.size() != 0) && mem_ready;
                if (do_pop)  void'(mq.pop_front());
                if (do_push) mq.push_back(drv);
                m_ready = (mq.size() < 2);
            end
        end
    endtask

    task automatic check_all();
        ex_mem_bundle_t h;
        logic           v;
        v = (mq.size() != 0);
        h = v ? mq[0] : m_last;
        check("mem_valid",   mem_valid,      v);
        check("ex_ready",    ex_ready,       m_ready);
        check("alu",         mem_alu_result, h.alu);
        check("fp",          mem_fp_result,  h.fp);
        check("addr",        mem_address,    h.addr);
        check("sdata",       mem_store_data, h.sdata);
        check("rd",          mem_rd_addr,    h.rd);
        check("width",       mem_width,      h.width);
        check("wb_sel",      mem_wb_sel,     h.wb_sel);
        check("mem_mwr",     mem_mwr,        v & h.mwr & h.mem_en);
        check("mem_read",    mem_read,       v & ~h.mwr & h.mem_en);
        check("wb_fp_en",    mem_wb_fp_en,   v & h.fp_en);
        check("wb_int_en",   mem_wb_int_en,  v & h.int_en);
        check("fwd_valid",   fwd_valid,      v & (h.fp_en | (h.int_en & (h.rd != 5'd0))));
        check("fwd_rd_addr", fwd_rd_addr,    h.rd);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0; drv = '0;
        #2 rst = 1'b0;

        // Reset held with random inputs
        repeat (3) begin
            drv = rand_b(); ex_valid = 1'($urandom); mem_ready = 1'($urandom); flush = 1'($urandom);
            cycle();
        end
        check("rst_ex_ready", ex_ready, 1'b0);
        check("rst_alu",      mem_alu_result, 32'h0);
        rst = 1'b1; ex_valid = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        cycle();
        check("ready_after_rst", ex_ready, 1'b1);

        // Streaming
        mem_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drv = rand_b(); drv.alu = i; ex_valid = 1'b1;
            cycle();
            check("stream_alu",   mem_alu_result, i);
            check("stream_valid", mem_valid, 1'b1);
        end
        ex_valid = 1'b0;
        cycle();

        // Stall
        mem_ready = 1'b0; ex_valid = 1'b1;
        drv = rand_b(); drv.alu = 32'hA; cycle();
        drv = rand_b(); drv.alu = 32'hB; cycle();
        check("stall_ready", ex_ready, 1'b0);
        check("stall_headA", mem_alu_result, 32'hA);
        ex_valid = 1'b0; mem_ready = 1'b1;
        cycle();
        check("stall_headB",  mem_alu_result, 32'hB);
        check("stall_ready1", ex_ready, 1'b1);
        cycle();
        check("stall_empty",  mem_valid, 1'b0);

        // Store then bubble
        drv = rand_b(); drv.mwr = 1'b1; drv.mem_en = 1'b1; drv.addr = 32'h100;
        ex_valid = 1'b1; mem_ready = 1'b1;
        cycle();
        check("store_mwr",  mem_mwr, 1'b1);
        check("store_addr", mem_address, 32'h100);
        ex_valid = 1'b0;
        cycle();
        check("bubble_mwr",  mem_mwr, 1'b0);
        check("bubble_read", mem_read, 1'b0);
        check("bubble_fp",   mem_wb_fp_en, 1'b0);
        check("bubble_int",  mem_wb_int_en, 1'b0);

        // Flush with a simultaneous push
        mem_ready = 1'b0; ex_valid = 1'b1;
        drv = rand_b(); drv.alu = 32'h1111; cycle();
        drv = rand_b(); drv.alu = 32'h2222; cycle();
        check("flush_full", ex_ready, 1'b0);
        drv = rand_b(); drv.alu = 32'hDEAD; flush = 1'b1;
        cycle();
        check("flush_valid", mem_valid, 1'b0);
        check("flush_ready", ex_ready, 1'b1);
        flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
        repeat (3) cycle();
        check("flush_gone", mem_valid, 1'b0);

        // Forwarding
        mem_ready = 1'b0;
        drv = rand_b(); drv.rd = 5'd7; drv.fp_en = 1'b1; drv.int_en = 1'b0; drv.wb_sel = WB_SEL_FP;
        ex_valid = 1'b1;
        cycle();
        ex_valid = 1'b0;
        check("fwd_fp_valid", fwd_valid, 1'b1);
        check("fwd_fp_rd",    fwd_rd_addr, 5'd7);
        mem_ready = 1'b1;
        cycle();
        drv = rand_b(); drv.rd = 5'd0; drv.fp_en = 1'b0; drv.int_en = 1'b1; drv.wb_sel = WB_SEL_ALU;
        ex_valid = 1'b1; mem_ready = 1'b0;
        cycle();
        ex_valid = 1'b0;
        check("fwd_x0_valid", fwd_valid, 1'b0);
        check("fwd_x0_head",  mem_valid, 1'b1);
        mem_ready = 1'b1;
        cycle();

        // Randomized traffic
        repeat (400) begin
            drv       = rand_b();
            ex_valid  = ($urandom_range(0, 3) != 0);
            mem_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
